video_timing: RTL and testbench

- Free-running raster timing generator for the composite encoder. Sits directly upstream of the test-pattern and frame-buffer pixel sources.
- Produces beam position (video_x, video_y), newline and newpixel strobes, and visible-line and visible-window qualifiers.
- Also produces the sync and colour-burst gates that the composite DAC mixer consumes.
- One progressive field of LINES_PER_FIELD lines repeats indefinitely (240p/288p style). There are no equalising pulses.

---
 rtl/video_timing_if.sv | 23 ++
 rtl/video_timing.sv | 120 ++++++++++++
 tb/tb_video_timing.sv | 133 +++++++++++++
 3 files changed

// File: rtl/video_timing_if.sv
// Raster timing bundle: beam position, strobes, qualifiers and sync/burst gates
// driven by video_timing toward the pixel sources and the composite mixer.
interface video_timing_if;
  logic [12:0] video_x;
  logic [8:0]  video_y;
  logic        newline;
  logic        newpixel;
  logic        visible_line;
  logic        visible_window;
  logic        sync;
  logic        burst_window;
  logic        field_odd;

  modport master (
    output video_x, video_y, newline, newpixel, visible_line, visible_window,
           sync, burst_window, field_odd
  );

  modport slave (
    input video_x, video_y, newline, newpixel, visible_line, visible_window,
          sync, burst_window, field_odd
  );
endinterface

// File: rtl/video_timing.sv
// Free-running progressive raster generator. Every output is decoded from the
// next beam position and registered, so all outputs describe the same position.
module video_timing #(
  parameter int unsigned CLKS_PER_LINE      = 3456,
  parameter int unsigned LINES_PER_FIELD    = 312,
  parameter int unsigned HSYNC_LEN          = 254,
  parameter int unsigned BURST_START        = 302,
  parameter int unsigned BURST_LEN          = 122,
  parameter int unsigned ACTIVE_START       = 567,
  parameter int unsigned ACTIVE_LEN         = 2808,
  parameter int unsigned CLKS_PER_PIXEL     = 8,
  parameter int unsigned FIRST_VISIBLE_LINE = 23,
  parameter int unsigned VISIBLE_LINES      = 256,
  parameter int unsigned VSYNC_LINES        = 3
) (
  input  logic           clk,
  input  logic           reset,
  video_timing_if.master vt
);

  localparam logic [12:0] LastX     = 13'(CLKS_PER_LINE - 1);
  localparam logic [8:0]  LastY     = 9'(LINES_PER_FIELD - 1);
  localparam logic [12:0] HsyncEnd  = 13'(HSYNC_LEN);
  localparam logic [12:0] HalfLine  = 13'(CLKS_PER_LINE / 2);
  localparam logic [12:0] BroadEnd0 = 13'(CLKS_PER_LINE / 2 - HSYNC_LEN);
  localparam logic [12:0] BroadEnd1 = 13'(CLKS_PER_LINE - HSYNC_LEN);
  localparam logic [12:0] BurstBeg  = 13'(BURST_START);
  localparam logic [12:0] BurstEnd  = 13'(BURST_START + BURST_LEN);
  localparam logic [12:0] ActBeg    = 13'(ACTIVE_START);
  localparam logic [12:0] ActEnd    = 13'(ACTIVE_START + ACTIVE_LEN);
  localparam logic [12:0] LastDiv   = 13'(CLKS_PER_PIXEL - 1);
  localparam logic [8:0]  VisBeg    = 9'(FIRST_VISIBLE_LINE);
  localparam logic [8:0]  VisEnd    = 9'(FIRST_VISIBLE_LINE + VISIBLE_LINES);
  localparam logic [8:0]  VsyncEnd  = 9'(VSYNC_LINES);

  // run_q is low for the first cycle after reset so that cycle presents (0,0).
  logic        run_q, run_d;
  logic [12:0] x_q, x_d;
  logic [8:0]  y_q, y_d;
  logic        field_q, field_d;
  logic [12:0] div_q, div_d;
  logic        newline_q, newline_d;
  logic        newpixel_q, newpixel_d;
  logic        vis_line_q, vis_line_d;
  logic        vis_win_q, vis_win_d;
  logic        sync_q, sync_d;
  logic        burst_q, burst_d;
  logic        broad;

  always_comb begin
    run_d   = 1'b1;
    x_d     = x_q + 13'd1;
    y_d     = y_q;
    field_d = field_q;
    if (!run_q) begin
      x_d = '0;
      y_d = '0;
    end else if (x_q == LastX) begin
      x_d = '0;
      if (y_q == LastY) begin
        y_d     = '0;
        field_d = ~field_q;
      end else begin
        y_d = y_q + 9'd1;
      end
    end

    // Divider is phase-aligned to the first active clock of each line.
    if (x_d == ActBeg || div_q == LastDiv) div_d = '0;
    else                                   div_d = div_q + 13'd1;

    broad      = (y_d < VsyncEnd);
    newline_d  = (x_d == 13'd0);
    vis_line_d = (y_d >= VisBeg) && (y_d < VisEnd);
    vis_win_d  = vis_line_d && (x_d >= ActBeg) && (x_d < ActEnd);
    newpixel_d = vis_win_d && (div_d == 13'd0);
    sync_d     = broad ? ((x_d < BroadEnd0) || ((x_d >= HalfLine) && (x_d < BroadEnd1)))
                       : (x_d < HsyncEnd);
    burst_d    = !broad && (x_d >= BurstBeg) && (x_d < BurstEnd);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_q      <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      field_q    <= 1'b0;
      div_q      <= '0;
      newline_q  <= 1'b0;
      newpixel_q <= 1'b0;
      vis_line_q <= 1'b0;
      vis_win_q  <= 1'b0;
      sync_q     <= 1'b0;
      burst_q    <= 1'b0;
    end else begin
      run_q      <= run_d;
      x_q        <= x_d;
      y_q        <= y_d;
      field_q    <= field_d;
      div_q      <= div_d;
      newline_q  <= newline_d;
      newpixel_q <= newpixel_d;
      vis_line_q <= vis_line_d;
      vis_win_q  <= vis_win_d;
      sync_q     <= sync_d;
      burst_q    <= burst_d;
    end
  end

  assign vt.video_x        = x_q;
  assign vt.video_y        = y_q;
  assign vt.field_odd      = field_q;
  assign vt.newline        = newline_q;
  assign vt.newpixel       = newpixel_q;
  assign vt.visible_line   = vis_line_q;
  assign vt.visible_window = vis_win_q;
  assign vt.sync           = sync_q;
  assign vt.burst_window   = burst_q;

endmodule

// File: tb/tb_video_timing.sv
// Scoreboarded bench for video_timing on a shrunken raster; expectations come
// from elapsed-clock arithmetic, a monitor compares every output each cycle.
module tb_video_timing;
  localparam int CPL = 96, LPF = 14, HS = 7, BS = 9, BL = 4, AS = 16, AL = 70, CPP = 3;
  localparam int FV = 4, VL = 8, VS = 2;
  localparam int FIELD = CPL * LPF;
  localparam int PIX_PER_LINE = (AL + CPP - 1) / CPP;

  typedef struct {
    int x, y, field, newline, newpixel, vline, vwin, sync, burst;
    bit rst;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  video_timing_if vt_bus ();

  video_timing #(
    .CLKS_PER_LINE(CPL), .LINES_PER_FIELD(LPF), .HSYNC_LEN(HS), .BURST_START(BS),
    .BURST_LEN(BL), .ACTIVE_START(AS), .ACTIVE_LEN(AL), .CLKS_PER_PIXEL(CPP),
    .FIRST_VISIBLE_LINE(FV), .VISIBLE_LINES(VL), .VSYNC_LINES(VS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .vt   (vt_bus.master)
  );

  always #5 clk = ~clk;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  // Reference: every output follows from the clock count t since reset release.
  function automatic exp_t model(int t);
    exp_t e;
    e.rst      = 1'b0;
    e.x        = t % CPL;
    e.y        = (t / CPL) % LPF;
    e.field    = (t / FIELD) % 2;
    e.newline  = int'(e.x == 0);
    e.vline    = int'(e.y >= FV && e.y < FV + VL);
    e.vwin     = int'(e.vline == 1 && e.x >= AS && e.x < AS + AL);
    e.newpixel = int'(e.vwin == 1 && ((e.x - AS) % CPP) == 0);
    if (e.y < VS) e.sync = int'(e.x < CPL / 2 - HS || (e.x >= CPL / 2 && e.x < CPL - HS));
    else          e.sync = int'(e.x < HS);
    e.burst    = int'(e.y >= VS && e.x >= BS && e.x < BS + BL);
    return e;
  endfunction

  function automatic exp_t reset_exp();
    exp_t e;
    e = '{default: 0};
    e.rst = 1'b1;
    return e;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (time %0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: one scoreboard entry per clock, compared just after the edge.
  initial begin : monitor
    exp_t e;
    int px_cnt = 0;
    bit line_full = 1'b0;
    bit prev_vis = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("video_x", int'(vt_bus.video_x), e.x);
        check("video_y", int'(vt_bus.video_y), e.y);
        check("field_odd", int'(vt_bus.field_odd), e.field);
        check("newline", int'(vt_bus.newline), e.newline);
        check("newpixel", int'(vt_bus.newpixel), e.newpixel);
        check("visible_line", int'(vt_bus.visible_line), e.vline);
        check("visible_window", int'(vt_bus.visible_window), e.vwin);
        check("sync", int'(vt_bus.sync), e.sync);
        check("burst_window", int'(vt_bus.burst_window), e.burst);
        if (e.rst) begin
          line_full = 1'b0;
          px_cnt = 0;
        end else begin
          if (e.newline == 1) begin
            if (line_full) check("pixels_per_line", px_cnt, prev_vis ? PIX_PER_LINE : 0);
            line_full = 1'b1;
            px_cnt = 0;
            prev_vis = (e.vline == 1);
          end
          if (vt_bus.newpixel === 1'b1) px_cnt++;
        end
      end
    end
  end

  task automatic drive(input bit r, inout int t);
    @(negedge clk);
    reset = r;
    if (r) begin
      sb_q.push_back(reset_exp());
      t = 0;
    end else begin
      sb_q.push_back(model(t));
      t++;
    end
  endtask

  initial begin : stimulus
    int t = 0;
    int n;
    for (int i = 0; i < 5; i++) drive(1'b1, t);
    // Cover two field wraps, then reset at a random point mid-field.
    n = 2 * FIELD + int'($urandom_range(CPL, FIELD - CPL));
    for (int i = 0; i < n; i++) drive(1'b0, t);
    drive(1'b1, t);
    n = FIELD + 2 * CPL + int'($urandom_range(0, CPL));
    for (int i = 0; i < n; i++) drive(1'b0, t);
    n = int'($urandom_range(1, 3));
    for (int i = 0; i < n; i++) drive(1'b1, t);
    for (int i = 0; i < 3 * CPL; i++) drive(1'b0, t);
    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
